// File: rtl/idli_pkg.sv
// -----------------------------------------------------------------------------
// idli_pkg
// Shared types and defaults for the idli fetch path.
//   fetch_entry_t : one buffered instruction, {instr, pc}, 16b each
//   FB_DEPTH      : default number of fetch buffer entries
// -----------------------------------------------------------------------------
package idli_pkg;

   localparam int FB_DEPTH = 2;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
   } fetch_entry_t;

endpackage : idli_pkg

// File: rtl/idli_fifo_m.sv
// -----------------------------------------------------------------------------
// idli_fifo_m
// Small synchronous FIFO with occupancy count. The head is read straight out
// of the storage flops, so data written on one edge is visible after it.
// A push into a full FIFO is accepted only when a pop happens on the same
// edge; a pop is ignored while empty (no bypass).
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (pointers and count only)
//   flush  in   empty the FIFO; overrides push and pop
//   push   in   write wdata
//   pop    in   advance the head
//   wdata  in   WIDTH-bit write data
//   rdata  out  WIDTH-bit head entry
//   vld    out  FIFO not empty
//   full   out  FIFO holds DEPTH entries
// -----------------------------------------------------------------------------
module idli_fifo_m #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             vld,
   output logic             full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             empty_s;
   logic             full_s;
   logic             do_push_s;
   logic             do_pop_s;

   // Accept decisions: full push only succeeds alongside a pop.
   always_comb begin
      empty_s   = (count_r == CNT_W'(0));
      full_s    = (count_r == CNT_W'(DEPTH));
      do_pop_s  = pop && !empty_s && !flush;
      if (full_s) begin
         do_push_s = push && do_pop_s;
      end else begin
         do_push_s = push && !flush;
      end
   end

   // Storage array; intentionally not reset.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointer and occupancy state; pointers wrap modulo DEPTH (power of two).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else if (flush) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign vld   = !empty_s;
   assign full  = full_s;

endmodule : idli_fifo_m

// File: rtl/idli_fetch_buf_m.sv
// -----------------------------------------------------------------------------
// idli_fetch_buf_m
// Assembles 4-bit SQI read nibbles (big-endian, first nibble = [15:12]) into
// 16-bit instruction words, tags each with its fetch PC and queues them in a
// DEPTH-entry FIFO for the decode stage.
// Ports:
//   i_fb_gck         in   core clock
//   i_fb_rst         in   synchronous active-high reset
//   i_fb_sqi_rd_vld  in   nibble valid this cycle
//   i_fb_sqi_data    in   4b nibble
//   i_fb_redir       in   redirect: drop buffered words and partial word
//   i_fb_redir_pc    in   16b new fetch address
//   o_fb_instr_vld   out  head entry valid
//   o_fb_instr       out  16b head instruction
//   o_fb_instr_pc    out  16b head instruction address
//   i_fb_instr_rdy   in   consumer takes head
//   o_fb_full        out  all entries occupied
//   o_fb_ovf         out  sticky: word completed while full with no pop
// -----------------------------------------------------------------------------
module idli_fetch_buf_m
   import idli_pkg::*;
#(
   parameter int DEPTH = FB_DEPTH
) (
   input  logic        i_fb_gck,
   input  logic        i_fb_rst,
   input  logic        i_fb_sqi_rd_vld,
   input  logic [3:0]  i_fb_sqi_data,
   input  logic        i_fb_redir,
   input  logic [15:0] i_fb_redir_pc,
   output logic        o_fb_instr_vld,
   output logic [15:0] o_fb_instr,
   output logic [15:0] o_fb_instr_pc,
   input  logic        i_fb_instr_rdy,
   output logic        o_fb_full,
   output logic        o_fb_ovf
);

   logic [15:0]  asm_r;
   logic [1:0]   nib_cnt_r;
   logic [15:0]  fetch_pc_r;
   logic         ovf_r;

   logic         word_done_s;
   logic         push_s;
   logic         pop_s;
   fetch_entry_t push_entry_s;
   fetch_entry_t head_entry_s;
   logic         head_vld_s;
   logic         full_s;

   // Word completion and FIFO handshakes; a redirect cancels both.
   always_comb begin
      word_done_s        = i_fb_sqi_rd_vld && (nib_cnt_r == 2'd3);
      push_s             = word_done_s && !i_fb_redir;
      pop_s              = head_vld_s && i_fb_instr_rdy && !i_fb_redir;
      push_entry_s.instr = {asm_r[15:4], i_fb_sqi_data};
      push_entry_s.pc    = fetch_pc_r;
   end

   // Nibble assembly, fetch PC and sticky overflow flag.
   always_ff @(posedge i_fb_gck) begin
      if (i_fb_rst) begin
         asm_r      <= 16'h0000;
         nib_cnt_r  <= 2'd0;
         fetch_pc_r <= 16'h0000;
         ovf_r      <= 1'b0;
      end else if (i_fb_redir) begin
         nib_cnt_r  <= 2'd0;
         fetch_pc_r <= i_fb_redir_pc;
      end else begin
         if (i_fb_sqi_rd_vld) begin
            // Each nibble lands in its final position so the 4th can be
            // concatenated directly onto [15:4] without a shift stage.
            case (nib_cnt_r)
               2'd0:    asm_r[15:12] <= i_fb_sqi_data;
               2'd1:    asm_r[11:8]  <= i_fb_sqi_data;
               2'd2:    asm_r[7:4]   <= i_fb_sqi_data;
               default: asm_r[3:0]   <= i_fb_sqi_data;
            endcase
            nib_cnt_r <= nib_cnt_r + 2'd1;
         end
         // PC advances even when the word is dropped on overflow.
         if (push_s) begin
            fetch_pc_r <= fetch_pc_r + 16'd1;
         end
         if (push_s && full_s && !pop_s) begin
            ovf_r <= 1'b1;
         end
      end
   end

   idli_fifo_m #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (i_fb_gck),
      .rst   (i_fb_rst),
      .flush (i_fb_redir),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (push_entry_s),
      .rdata (head_entry_s),
      .vld   (head_vld_s),
      .full  (full_s)
   );

   assign o_fb_instr_vld = head_vld_s;
   assign o_fb_instr     = head_entry_s.instr;
   assign o_fb_instr_pc  = head_entry_s.pc;
   assign o_fb_full      = full_s;
   assign o_fb_ovf       = ovf_r;

endmodule : idli_fetch_buf_m

// File: tb/tb_idli_fetch_buf_m.sv
// -----------------------------------------------------------------------------
// tb_idli_fetch_buf_m
// Directed bench for idli_fetch_buf_m (DEPTH = 2). Inputs change 1 time unit
// after a rising edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_idli_fetch_buf_m;

   logic        gck = 1'b0;
   logic        rst;
   logic        sqi_vld;
   logic [3:0]  sqi_data;
   logic        redir;
   logic [15:0] redir_pc;
   logic        instr_vld;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_rdy;
   logic        full;
   logic        ovf;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 gck = ~gck;

   idli_fetch_buf_m #(.DEPTH(2)) dut (
      .i_fb_gck        (gck),
      .i_fb_rst        (rst),
      .i_fb_sqi_rd_vld (sqi_vld),
      .i_fb_sqi_data   (sqi_data),
      .i_fb_redir      (redir),
      .i_fb_redir_pc   (redir_pc),
      .o_fb_instr_vld  (instr_vld),
      .o_fb_instr      (instr),
      .o_fb_instr_pc   (instr_pc),
      .i_fb_instr_rdy  (instr_rdy),
      .o_fb_full       (full),
      .o_fb_ovf        (ovf)
   );

   task automatic tick();
      @(posedge gck);
      #1;
   endtask

   task automatic nib(input logic [3:0] d);
      sqi_vld  = 1'b1;
      sqi_data = d;
      tick();
      sqi_vld  = 1'b0;
   endtask

   task automatic push_word(input logic [15:0] w);
      for (int i = 0; i < 4; i++) begin
         nib(w[15-4*i -: 4]);
      end
   endtask

   task automatic do_redir(input logic [15:0] pc);
      redir    = 1'b1;
      redir_pc = pc;
      tick();
      redir    = 1'b0;
   endtask

   task automatic do_pop();
      instr_rdy = 1'b1;
      tick();
      instr_rdy = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      total_cnt++; if (instr_vld !== 1'b0) $display("FAIL reset_vld got %b exp %b", instr_vld, 1'b0); else pass_cnt++;
      total_cnt++; if (full !== 1'b0) $display("FAIL reset_full got %b exp %b", full, 1'b0); else pass_cnt++;
      total_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b exp %b", ovf, 1'b0); else pass_cnt++;
   endtask

   task automatic test_basic();
      do_redir(16'h0100);
      nib(4'h1); nib(4'h2); nib(4'h3);
      total_cnt++; if (instr_vld !== 1'b0) $display("FAIL basic_partial_vld got %b exp %b", instr_vld, 1'b0); else pass_cnt++;
      nib(4'h4);
      total_cnt++; if (instr_vld !== 1'b1) $display("FAIL basic_vld got %b exp %b", instr_vld, 1'b1); else pass_cnt++;
      total_cnt++; if (instr !== 16'h1234) $display("FAIL basic_instr got %h exp %h", instr, 16'h1234); else pass_cnt++;
      total_cnt++; if (instr_pc !== 16'h0100) $display("FAIL basic_pc got %h exp %h", instr_pc, 16'h0100); else pass_cnt++;
      do_pop();
      total_cnt++; if (instr_vld !== 1'b0) $display("FAIL basic_pop_vld got %b exp %b", instr_vld, 1'b0); else pass_cnt++;
   endtask

   task automatic test_gap();
      nib(4'hA); nib(4'hB);
      tick(); tick(); tick();
      total_cnt++; if (instr_vld !== 1'b0) $display("FAIL gap_partial_vld got %b exp %b", instr_vld, 1'b0); else pass_cnt++;
      nib(4'hC); nib(4'hD);
      total_cnt++; if (instr !== 16'hABCD) $display("FAIL gap_instr got %h exp %h", instr, 16'hABCD); else pass_cnt++;
      total_cnt++; if (instr_pc !== 16'h0101) $display("FAIL gap_pc got %h exp %h", instr_pc, 16'h0101); else pass_cnt++;
      total_cnt++; if (full !== 1'b0) $display("FAIL gap_single_full got %b exp %b", full, 1'b0); else pass_cnt++;
      do_pop();
      total_cnt++; if (instr_vld !== 1'b0) $display("FAIL gap_single_push got %b exp %b", instr_vld, 1'b0); else pass_cnt++;
   endtask

   task automatic test_full_ovf();
      do_redir(16'h0100);
      push_word(16'h1111);
      total_cnt++; if (full !== 1'b0) $display("FAIL ovf_one_full got %b exp %b", full, 1'b0); else pass_cnt++;
      push_word(16'h2222);
      total_cnt++; if (full !== 1'b1) $display("FAIL ovf_full got %b exp %b", full, 1'b1); else pass_cnt++;
      total_cnt++; if (ovf !== 1'b0) $display("FAIL ovf_early got %b exp %b", ovf, 1'b0); else pass_cnt++;
      push_word(16'h3333);
      total_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_set got %b exp %b", ovf, 1'b1); else pass_cnt++;
      total_cnt++; if (instr !== 16'h1111) $display("FAIL ovf_head got %h exp %h", instr, 16'h1111); else pass_cnt++;
      total_cnt++; if (instr_pc !== 16'h0100) $display("FAIL ovf_head_pc got %h exp %h", instr_pc, 16'h0100); else pass_cnt++;
   endtask

   task automatic test_full_push_pop();
      // FIFO holds 0x1111/0x0100 and 0x2222/0x0101; fetch PC is 0x0103.
      nib(4'h4); nib(4'h4); nib(4'h4);
      instr_rdy = 1'b1;
      nib(4'h4);
      instr_rdy = 1'b0;
      total_cnt++; if (full !== 1'b1) $display("FAIL pp_full got %b exp %b", full, 1'b1); else pass_cnt++;
      total_cnt++; if (instr !== 16'h2222) $display("FAIL pp_head got %h exp %h", instr, 16'h2222); else pass_cnt++;
      total_cnt++; if (instr_pc !== 16'h0101) $display("FAIL pp_head_pc got %h exp %h", instr_pc, 16'h0101); else pass_cnt++;
      do_pop();
      total_cnt++; if (instr !== 16'h4444) $display("FAIL pp_second got %h exp %h", instr, 16'h4444); else pass_cnt++;
      total_cnt++; if (instr_pc !== 16'h0103) $display("FAIL pp_second_pc got %h exp %h", instr_pc, 16'h0103); else pass_cnt++;
      do_pop();
      total_cnt++; if (instr_vld !== 1'b0) $display("FAIL pp_drain got %b exp %b", instr_vld, 1'b0); else pass_cnt++;
   endtask

   task automatic test_redir();
      push_word(16'h7777);
      nib(4'h9); nib(4'h9);
      redir    = 1'b1;
      redir_pc = 16'h8000;
      sqi_vld  = 1'b1;
      sqi_data = 4'hF;
      instr_rdy = 1'b1;
      tick();
      redir    = 1'b0;
      sqi_vld  = 1'b0;
      instr_rdy = 1'b0;
      total_cnt++; if (instr_vld !== 1'b0) $display("FAIL redir_vld got %b exp %b", instr_vld, 1'b0); else pass_cnt++;
      total_cnt++; if (ovf !== 1'b1) $display("FAIL redir_ovf_sticky got %b exp %b", ovf, 1'b1); else pass_cnt++;
      push_word(16'h5678);
      total_cnt++; if (instr !== 16'h5678) $display("FAIL redir_instr got %h exp %h", instr, 16'h5678); else pass_cnt++;
      total_cnt++; if (instr_pc !== 16'h8000) $display("FAIL redir_pc got %h exp %h", instr_pc, 16'h8000); else pass_cnt++;
      total_cnt++; if (full !== 1'b0) $display("FAIL redir_single got %b exp %b", full, 1'b0); else pass_cnt++;
      do_pop();
   endtask

   task automatic test_wrap_and_reset();
      do_redir(16'hFFFF);
      push_word(16'h1357);
      push_word(16'h2468);
      total_cnt++; if (instr_pc !== 16'hFFFF) $display("FAIL wrap_pc0 got %h exp %h", instr_pc, 16'hFFFF); else pass_cnt++;
      total_cnt++; if (instr !== 16'h1357) $display("FAIL wrap_instr0 got %h exp %h", instr, 16'h1357); else pass_cnt++;
      do_pop();
      total_cnt++; if (instr_pc !== 16'h0000) $display("FAIL wrap_pc1 got %h exp %h", instr_pc, 16'h0000); else pass_cnt++;
      total_cnt++; if (instr !== 16'h2468) $display("FAIL wrap_instr1 got %h exp %h", instr, 16'h2468); else pass_cnt++;
      // Reset mid-word, with a redirect asserted at the same edge.
      nib(4'hA); nib(4'hB);
      rst      = 1'b1;
      redir    = 1'b1;
      redir_pc = 16'h1234;
      tick();
      rst      = 1'b0;
      redir    = 1'b0;
      total_cnt++; if (instr_vld !== 1'b0) $display("FAIL rst_mid_vld got %b exp %b", instr_vld, 1'b0); else pass_cnt++;
      total_cnt++; if (ovf !== 1'b0) $display("FAIL rst_mid_ovf got %b exp %b", ovf, 1'b0); else pass_cnt++;
      push_word(16'hCDEF);
      total_cnt++; if (instr !== 16'hCDEF) $display("FAIL rst_mid_instr got %h exp %h", instr, 16'hCDEF); else pass_cnt++;
      total_cnt++; if (instr_pc !== 16'h0000) $display("FAIL rst_mid_pc got %h exp %h", instr_pc, 16'h0000); else pass_cnt++;
   endtask

   initial begin
      rst       = 1'b0;
      sqi_vld   = 1'b0;
      sqi_data  = 4'h0;
      redir     = 1'b0;
      redir_pc  = 16'h0000;
      instr_rdy = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_gap();
      test_full_ovf();
      test_full_push_pop();
      test_redir();
      test_wrap_and_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_idli_fetch_buf_m
